// File: rtl/trng_key_fetcher_if.sv
// ---------------------------------------------------------------------------
// trng_key_fetcher_if
//
// OBI request/response bundle between the key fetcher (requester) and the
// TRNG OBI slave port. Only the subset of OBI fields the fetcher uses is
// carried here.
//
// Signals:
//   req, addr, we, be, wdata  - request channel, driven by the master
//   gnt, rvalid, rdata        - response channel, driven by the slave
//
// Modports:
//   master - the initiator side (trng_key_fetcher)
//   slave  - the TRNG side (or a bus model in simulation)
// ---------------------------------------------------------------------------
interface trng_key_fetcher_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/trng_key_fetcher.sv
// ---------------------------------------------------------------------------
// trng_key_fetcher
//
// OBI initiator that pulls entropy words out of the TRNG peripheral and
// assembles them into a 32*N_WORDS-bit key for the Keccak path. For every
// word it polls the TRNG status register until the ready bit is set, then
// reads the data register. Once all words are in, the key is presented with
// a valid/ack handshake and zeroized on acknowledge.
//
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous reset, active-high
//   obi          - OBI master port (req/addr/we/be/wdata out, gnt/rvalid/rdata in)
//   start_i      - single-cycle pulse requesting a new key (IDLE or ERROR only)
//   busy_o       - high while fetching words
//   key_o        - assembled key, word i at [32*i +: 32]
//   key_valid_o  - key complete and stable
//   key_ack_i    - consumer has taken the key
//   err_o        - poll timeout occurred
//
// Configuration macro:
//   TRNG_FETCH_TIMEOUT_EN - when defined, POLL_LIMIT consecutive not-ready
//   status reads send the FSM to ERROR. When undefined the FSM polls forever,
//   ERROR is unreachable and err_o is tied low.
// ---------------------------------------------------------------------------
module trng_key_fetcher #(
  parameter int unsigned N_WORDS     = 8,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_0008,
  parameter logic [31:0] DATA_ADDR   = 32'h0000_0000,
  parameter int unsigned READY_BIT   = 0,
  parameter int unsigned POLL_LIMIT  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  trng_key_fetcher_if.master     obi,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic [32*N_WORDS-1:0]  key_o,
  output logic                   key_valid_o,
  input  logic                   key_ack_i,
  output logic                   err_o
);

  localparam int unsigned KEY_W  = 32 * N_WORDS;
  localparam int unsigned WCNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [4:0]  READY_IDX = READY_BIT[4:0];

  typedef enum logic [2:0] {
    IDLE,
    STAT_REQ,
    STAT_RSP,
    DATA_REQ,
    DATA_RSP,
    DONE,
    ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                req_q, req_d;
  logic [31:0]         addr_q, addr_d;

`ifdef TRNG_FETCH_TIMEOUT_EN
  localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
`else
  // POLL_LIMIT only matters with the timeout enabled.
  logic unused_poll_limit;
  assign unused_poll_limit = (POLL_LIMIT == 0);
`endif

  // State register and datapath flops. The OBI request is registered so the
  // request channel never depends combinationally on the response channel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      wcnt_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
`ifdef TRNG_FETCH_TIMEOUT_EN
      poll_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      wcnt_q  <= wcnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
`ifdef TRNG_FETCH_TIMEOUT_EN
      poll_cnt_q <= poll_cnt_d;
`endif
    end
  end

  // Next-state and datapath update. The registered request is derived from
  // the next state, so req/addr appear in the first cycle of a *_REQ state
  // and drop the cycle after gnt is sampled.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    wcnt_d  = wcnt_q;
`ifdef TRNG_FETCH_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = STAT_REQ;
          key_d   = '0;
          wcnt_d  = '0;
`ifdef TRNG_FETCH_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end

      STAT_REQ: begin
        if (obi.gnt) state_d = STAT_RSP;
      end

      STAT_RSP: begin
        if (obi.rvalid) begin
          if (obi.rdata[READY_IDX]) begin
            state_d = DATA_REQ;
          end else begin
`ifdef TRNG_FETCH_TIMEOUT_EN
            // This response is the (poll_cnt_q+1)-th consecutive not-ready read.
            poll_cnt_d = poll_cnt_q + POLL_W'(1);
            if (poll_cnt_q == POLL_W'(POLL_LIMIT - 1)) state_d = ERROR;
            else                                       state_d = STAT_REQ;
`else
            state_d = STAT_REQ;
`endif
          end
        end
      end

      DATA_REQ: begin
        if (obi.gnt) state_d = DATA_RSP;
      end

      DATA_RSP: begin
        if (obi.rvalid) begin
          for (int i = 0; i < int'(N_WORDS); i++) begin
            if (wcnt_q == WCNT_W'(i)) key_d[32*i +: 32] = obi.rdata;
          end
`ifdef TRNG_FETCH_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
          if (wcnt_q == WCNT_W'(N_WORDS - 1)) begin
            state_d = DONE;
          end else begin
            wcnt_d  = wcnt_q + WCNT_W'(1);
            state_d = STAT_REQ;
          end
        end
      end

      DONE: begin
        if (key_ack_i) begin
          state_d = IDLE;
          key_d   = '0;
        end
      end

      ERROR: begin
        // Partial key is kept here until the retry start clears it.
        if (start_i) begin
          state_d = STAT_REQ;
          key_d   = '0;
          wcnt_d  = '0;
`ifdef TRNG_FETCH_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    req_d  = (state_d == STAT_REQ) || (state_d == DATA_REQ);
    addr_d = (state_d == STAT_REQ) ? STATUS_ADDR :
             (state_d == DATA_REQ) ? DATA_ADDR   : 32'h0;
  end

  // Status outputs decoded from the current state only.
  always_comb begin
    busy_o      = (state_q == STAT_REQ) || (state_q == STAT_RSP) ||
                  (state_q == DATA_REQ) || (state_q == DATA_RSP);
    key_valid_o = (state_q == DONE);
`ifdef TRNG_FETCH_TIMEOUT_EN
    err_o       = (state_q == ERROR);
`else
    err_o       = 1'b0;
`endif
  end

  assign key_o     = key_q;
  assign obi.req   = req_q;
  assign obi.addr  = addr_q;
  assign obi.we    = 1'b0;
  assign obi.be    = 4'hF;
  assign obi.wdata = 32'h0;

endmodule

// File: tb/tb_trng_key_fetcher.sv
// ---------------------------------------------------------------------------
// tb_trng_key_fetcher
//
// Directed bench for trng_key_fetcher (N_WORDS=8, POLL_LIMIT=4). A small OBI
// slave model answers status reads (not-ready for a configurable number of
// reads per word) and data reads (base + word index), with a configurable
// grant delay and a one-cycle response latency.
// ---------------------------------------------------------------------------
module tb_trng_key_fetcher;

  localparam int          KEY_W       = 256;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_0008;
  localparam logic [31:0] DATA_ADDR   = 32'h0000_0000;

`ifdef TRNG_FETCH_TIMEOUT_EN
  // Stay below the 4-read timeout in the stalled vector.
  localparam int NR1      = 3;
  localparam int NR1_LAT  = 201;
  localparam int NR1_STAT = 32;
`else
  localparam int NR1      = 5;
  localparam int NR1_LAT  = 281;
  localparam int NR1_STAT = 48;
`endif

  logic             clk;
  logic             rst_i;
  logic             start_i;
  logic             busy_o;
  logic [KEY_W-1:0] key_o;
  logic             key_valid_o;
  logic             key_ack_i;
  logic             err_o;

  trng_key_fetcher_if bus();

  trng_key_fetcher #(
    .N_WORDS     (8),
    .STATUS_ADDR (STATUS_ADDR),
    .DATA_ADDR   (DATA_ADDR),
    .READY_BIT   (0),
    .POLL_LIMIT  (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .obi         (bus),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .key_ack_i   (key_ack_i),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model configuration, written only by the stimulus process.
  int          gnt_delay;
  int          notready_cfg;
  bit          never_ready;
  bit          mute_data;
  bit          slave_clear;
  logic [31:0] data_base;
  logic        inject_rvalid;
  logic [31:0] inject_rdata;

  // Slave model state.
  int          wait_cnt;
  int          stat_since_data;
  int          stat_reads;
  int          data_reads;
  int          data_idx;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  assign bus.gnt    = bus.req && (wait_cnt >= gnt_delay);
  assign bus.rvalid = rvalid_q | inject_rvalid;
  assign bus.rdata  = inject_rvalid ? inject_rdata : rdata_q;

  // Slave: grant after gnt_delay cycles of req, respond one cycle after grant.
  always @(posedge clk) begin
    if (slave_clear) begin
      wait_cnt        <= 0;
      stat_since_data <= 0;
      stat_reads      <= 0;
      data_reads      <= 0;
      data_idx        <= 0;
      rvalid_q        <= 1'b0;
      rdata_q         <= 32'h0;
    end else begin
      rvalid_q <= 1'b0;
      if (bus.req && !bus.gnt) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
      if (bus.req && bus.gnt) begin
        if (bus.addr == STATUS_ADDR) begin
          stat_reads <= stat_reads + 1;
          rvalid_q   <= 1'b1;
          if (never_ready || stat_since_data < notready_cfg) begin
            rdata_q         <= 32'hFFFF_FFFE;
            stat_since_data <= stat_since_data + 1;
          end else begin
            rdata_q <= 32'h0000_0001;
          end
        end else begin
          data_reads      <= data_reads + 1;
          stat_since_data <= 0;
          rdata_q         <= data_base + 32'(data_idx);
          data_idx        <= data_idx + 1;
          rvalid_q        <= !mute_data;
        end
      end
    end
  end

  // Bus protocol monitor: legal read-only requests, addr held while waiting.
  int          proto_bad;
  logic        prev_hold;
  logic [31:0] prev_addr;
  initial begin
    proto_bad = 0;
    prev_hold = 1'b0;
    prev_addr = 32'h0;
  end
  always @(posedge clk) begin
    if (bus.req && !(bus.addr == STATUS_ADDR || bus.addr == DATA_ADDR)) proto_bad++;
    if (bus.we !== 1'b0 || bus.be !== 4'hF || bus.wdata !== 32'h0) proto_bad++;
    if (prev_hold && (bus.req !== 1'b1 || bus.addr !== prev_addr)) proto_bad++;
    prev_hold <= bus.req && !bus.gnt && !rst_i;
    prev_addr <= bus.addr;
  end

  int checks;
  int errors;

  typedef struct {
    int               gnt_delay;
    int               notready;
    logic [31:0]      base;
    bit               start_mid;
    int               exp_latency;
    int               exp_stat;
    int               exp_data;
    logic [KEY_W-1:0] exp_key;
  } vec_t;

  vec_t vecs[3];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [KEY_W-1:0] act,
                             input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearSlave;
    slave_clear = 1'b1;
    tick();
    slave_clear = 1'b0;
  endtask

  // Pulse start and wait (bounded) for key_valid; optionally pulse start
  // again mid-fetch, which the DUT must ignore.
  task automatic applyStimulus(input bit start_mid, output int lat,
                               output logic first_req, output logic first_busy);
    start_i = 1'b1;
    tick();
    start_i    = 1'b0;
    lat        = 1;
    first_req  = bus.req;
    first_busy = busy_o;
    while (!key_valid_o && lat < 2000) begin
      start_i = (start_mid && lat == 40);
      tick();
      lat++;
    end
    start_i = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    int   lat;
    int   hold_bad;
    logic first_req;
    logic first_busy;
    gnt_delay    = v.gnt_delay;
    notready_cfg = v.notready;
    data_base    = v.base;
    never_ready  = 1'b0;
    mute_data    = 1'b0;
    clearSlave();
    applyStimulus(v.start_mid, lat, first_req, first_busy);
    checkOutput("req_after_start", KEY_W'(first_req), KEY_W'(1));
    checkOutput("busy_after_start", KEY_W'(first_busy), KEY_W'(1));
    checkOutput("latency", KEY_W'(lat), KEY_W'(v.exp_latency));
    checkOutput("key", key_o, v.exp_key);
    checkOutput("status_reads", KEY_W'(stat_reads), KEY_W'(v.exp_stat));
    checkOutput("data_reads", KEY_W'(data_reads), KEY_W'(v.exp_data));
    checkOutput("busy_in_done", KEY_W'(busy_o), KEY_W'(0));
    checkOutput("err_in_done", KEY_W'(err_o), KEY_W'(0));
    // Hold off ack; a start pulse here must be ignored.
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      start_i = (i == 3);
      tick();
      if (key_o !== v.exp_key || key_valid_o !== 1'b1 || bus.req !== 1'b0) hold_bad++;
    end
    start_i = 1'b0;
    checkOutput("key_hold", KEY_W'(hold_bad), KEY_W'(0));
    key_ack_i = 1'b1;
    tick();
    key_ack_i = 1'b0;
    checkOutput("valid_after_ack", KEY_W'(key_valid_o), KEY_W'(0));
    checkOutput("key_after_ack", key_o, KEY_W'(0));
    tick();
    checkOutput("req_idle", KEY_W'(bus.req), KEY_W'(0));
  endtask

  initial begin
    int n;
    int req_seen;
    checks        = 0;
    errors        = 0;
    rst_i         = 1'b1;
    start_i       = 1'b0;
    key_ack_i     = 1'b0;
    gnt_delay     = 0;
    notready_cfg  = 0;
    never_ready   = 1'b0;
    mute_data     = 1'b0;
    slave_clear   = 1'b1;
    data_base     = 32'h0;
    inject_rvalid = 1'b0;
    inject_rdata  = 32'h0;

    vecs[0] = '{0, 0, 32'h0000_00A0, 1'b0, 33, 8, 8,
                256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0};
    vecs[1] = '{3, NR1, 32'h0000_00B0, 1'b1, NR1_LAT, NR1_STAT, 8,
                256'h000000B7_000000B6_000000B5_000000B4_000000B3_000000B2_000000B1_000000B0};
    vecs[2] = '{1, 1, 32'h1234_5600, 1'b0, 73, 16, 8,
                256'h12345607_12345606_12345605_12345604_12345603_12345602_12345601_12345600};

    // Reset values.
    tick();
    tick();
    slave_clear = 1'b0;
    rst_i = 1'b0;
    checkOutput("rst_req", KEY_W'(bus.req), KEY_W'(0));
    checkOutput("rst_addr", KEY_W'(bus.addr), KEY_W'(0));
    checkOutput("rst_busy", KEY_W'(busy_o), KEY_W'(0));
    checkOutput("rst_valid", KEY_W'(key_valid_o), KEY_W'(0));
    checkOutput("rst_key", key_o, KEY_W'(0));
    checkOutput("rst_err", KEY_W'(err_o), KEY_W'(0));
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.req !== 1'b0) req_seen++;
    end
    checkOutput("idle_no_req", KEY_W'(req_seen), KEY_W'(0));

    // Table-driven full key fetches.
    for (int v = 0; v < 3; v++) runVector(vecs[v]);

    // Reset during DATA_RSP, then a stale rvalid after reset.
    gnt_delay    = 0;
    notready_cfg = 0;
    data_base    = 32'h0000_00D0;
    mute_data    = 1'b1;
    clearSlave();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (data_reads == 0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("reached_data_rsp", KEY_W'(data_reads), KEY_W'(1));
    tick();
    checkOutput("busy_in_data_rsp", KEY_W'(busy_o), KEY_W'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    inject_rdata  = 32'hDEAD_BEEF;
    inject_rvalid = 1'b1;
    tick();
    inject_rvalid = 1'b0;
    tick();
    checkOutput("midrst_key", key_o, KEY_W'(0));
    checkOutput("midrst_busy", KEY_W'(busy_o), KEY_W'(0));
    checkOutput("midrst_valid", KEY_W'(key_valid_o), KEY_W'(0));
    checkOutput("midrst_req", KEY_W'(bus.req), KEY_W'(0));
    mute_data = 1'b0;
    runVector(vecs[0]);

`ifdef TRNG_FETCH_TIMEOUT_EN
    // Timeout after two good words; partial key retained, then a retry.
    gnt_delay    = 0;
    notready_cfg = 0;
    data_base    = 32'h0000_00E0;
    clearSlave();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (data_reads < 2 && n < 200) begin
      tick();
      n++;
    end
    never_ready = 1'b1;
    n = 0;
    while (!err_o && n < 200) begin
      tick();
      n++;
    end
    checkOutput("timeout_err", KEY_W'(err_o), KEY_W'(1));
    checkOutput("timeout_stat_reads", KEY_W'(stat_reads), KEY_W'(6));
    checkOutput("timeout_busy", KEY_W'(busy_o), KEY_W'(0));
    checkOutput("timeout_partial_key", key_o, KEY_W'(64'h000000E1_000000E0));
    tick();
    checkOutput("error_no_req", KEY_W'(bus.req), KEY_W'(0));
    never_ready = 1'b0;
    clearSlave();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checkOutput("retry_err_clear", KEY_W'(err_o), KEY_W'(0));
    checkOutput("retry_key_clear", key_o, KEY_W'(0));
    n = 1;
    while (!key_valid_o && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("retry_latency", KEY_W'(n), KEY_W'(33));
    checkOutput("retry_key", key_o,
                256'h000000E7_000000E6_000000E5_000000E4_000000E3_000000E2_000000E1_000000E0);
    key_ack_i = 1'b1;
    tick();
    key_ack_i = 1'b0;
`endif

    checkOutput("bus_protocol", KEY_W'(proto_bad), KEY_W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
